// File: rtl/enigma_pkg.sv
// Shared types and modular arithmetic for the rotor stack.
package enigma_pkg;
    localparam int ALPHA_DEF = 26;
    localparam int BASE_DEF  = 65;
    // Callers zero-extend their IW-bit indices into this width; the upper bits stay zero.
    localparam int MOD_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    function automatic int calc_iw(input int alpha);
        return (alpha <= 2) ? 1 : $clog2(alpha);
    endfunction

    // (a + b) mod m for a, b < m: one add, one conditional subtract
    function automatic logic [MOD_W-1:0] mod_add(input logic [MOD_W-1:0] a,
                                                  input logic [MOD_W-1:0] b,
                                                  input logic [MOD_W-1:0] m);
        logic [MOD_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[MOD_W-1:0];
    endfunction

    function automatic logic [MOD_W-1:0] mod_sub(input logic [MOD_W-1:0] a,
                                                  input logic [MOD_W-1:0] b,
                                                  input logic [MOD_W-1:0] m);
        logic [MOD_W:0] s;
        s = {1'b0, a} + {1'b0, m} - {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[MOD_W-1:0];
    endfunction
endpackage

// File: rtl/enigma_rotor_cell.sv
// One rotor: wiring/position/step registers, forward and inverse lookup, and
// the wrap flag that carries into the next rotor.
module enigma_rotor_cell import enigma_pkg::*; #(
    parameter int ALPHA = ALPHA_DEF,
    parameter int IW    = calc_iw(ALPHA)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cfg_we,
    input  logic [ALPHA*IW-1:0] cfg_wiring,
    input  logic [IW-1:0]       cfg_pos,
    input  logic [IW-1:0]       cfg_step,
    input  logic                advance,
    output logic                wrap,
    input  logic [IW-1:0]       idx_in,
    output logic [IW-1:0]       fwd_out,
    output logic [IW-1:0]       inv_out
);
    localparam logic [MOD_W-1:0] M       = MOD_W'(ALPHA);
    localparam logic [IW:0]      ALPHA_X = (IW+1)'(ALPHA);

    logic [ALPHA*IW-1:0] wiring;
    logic [IW-1:0]       pos;
    logic [IW-1:0]       step;
    logic [IW-1:0]       fwd_addr;
    logic [IW-1:0]       inv_j;
    logic                inv_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wiring <= '0;
            pos    <= '0;
            step   <= '0;
        end else if (cfg_we) begin
            wiring <= cfg_wiring;
            pos    <= cfg_pos;
            step   <= cfg_step;
        end else if (advance) begin
            pos <= IW'(mod_add(MOD_W'(pos), MOD_W'(step), M));
        end
    end

    assign wrap = ({1'b0, pos} + {1'b0, step}) >= ALPHA_X;

    always_comb begin
        fwd_addr = IW'(mod_add(MOD_W'(idx_in), MOD_W'(pos), M));
        fwd_out  = '0;
        for (int k = 0; k < ALPHA; k++) begin
            if (fwd_addr == IW'(k)) fwd_out = wiring[k*IW +: IW];
        end
        // Descending scan so the lowest matching entry wins.
        inv_hit = 1'b0;
        inv_j   = '0;
        for (int j = ALPHA - 1; j >= 0; j--) begin
            if (wiring[j*IW +: IW] == idx_in) begin
                inv_hit = 1'b1;
                inv_j   = IW'(j);
            end
        end
        inv_out = inv_hit ? IW'(mod_sub(MOD_W'(inv_j), MOD_W'(pos), M)) : idx_in;
    end
endmodule

// File: rtl/enigma_rotor_stack.sv
// Multi-rotor substitution cipher, one rotor per cycle, odometer stepping.
// Optional REFLECTOR_EN adds a reflector slot and a forward/reflect/inverse path.
module enigma_rotor_stack import enigma_pkg::*; #(
    parameter  int NUM_ROTORS = 3,
    parameter  int ALPHA      = ALPHA_DEF,
    parameter  int SYM_W      = 8,
    parameter  int BASE       = BASE_DEF,
    localparam int IW         = calc_iw(ALPHA)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cfg_we,
    input  logic [2:0]          cfg_sel,
    input  logic [ALPHA*IW-1:0] cfg_wiring,
    input  logic [IW-1:0]       cfg_pos,
    input  logic [IW-1:0]       cfg_step,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SYM_W-1:0]    in_sym,
    input  logic                in_dec,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SYM_W-1:0]    out_sym,
    output logic                busy
);
`ifdef REFLECTOR_EN
    localparam int NUM_CELLS  = NUM_ROTORS + 1;
    localparam int NUM_STAGES = 2 * NUM_ROTORS + 1;
`else
    localparam int NUM_CELLS  = NUM_ROTORS;
    localparam int NUM_STAGES = NUM_ROTORS;
`endif
    localparam int            SW   = $clog2(NUM_STAGES + 1);
    localparam logic [SW-1:0] LAST = SW'(NUM_STAGES - 1);

    state_t            state, state_nxt;
    logic [SW-1:0]     stage_q;
    logic [SYM_W-1:0]  sym_q;
    logic              dec_q;
    logic              oob_q;
    logic [IW-1:0]     idx_q;
    logic [SYM_W-1:0]  out_sym_q;
    logic [IW-1:0]     stage_res;
    logic              in_oob;
    logic [IW-1:0]     in_idx;
    logic              out_hs;

    logic [IW-1:0] fwd_out [NUM_CELLS];
    logic [IW-1:0] inv_out [NUM_CELLS];
    logic          wrap    [NUM_CELLS];
    logic          adv     [NUM_CELLS];
    logic          cell_we [NUM_CELLS];

    assign in_oob = (in_sym < SYM_W'(BASE)) || (in_sym >= SYM_W'(BASE + ALPHA));
    assign in_idx = IW'(in_sym - SYM_W'(BASE));
    assign out_hs = (state == OUT) && out_ready;

    for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
        assign cell_we[c] = cfg_we && (state == IDLE) && (int'(cfg_sel) == c);

        // Odometer: only the rotor below us wrapping lets us advance.
        if (c == 0) begin : g_first
            assign adv[c] = out_hs && !oob_q;
        end else if (c < NUM_ROTORS) begin : g_chain
            assign adv[c] = adv[c-1] && wrap[c-1];
        end else begin : g_refl
            assign adv[c] = 1'b0;
        end

        enigma_rotor_cell #(.ALPHA(ALPHA), .IW(IW)) u_cell (
            .clk        (clk),
            .reset_n    (reset_n),
            .cfg_we     (cell_we[c]),
            .cfg_wiring (cfg_wiring),
            .cfg_pos    (cfg_pos),
            .cfg_step   (cfg_step),
            .advance    (adv[c]),
            .wrap       (wrap[c]),
            .idx_in     (idx_q),
            .fwd_out    (fwd_out[c]),
            .inv_out    (inv_out[c])
        );
    end

    always_comb begin
        stage_res = idx_q;
        for (int i = 0; i < NUM_ROTORS; i++) begin
`ifdef REFLECTOR_EN
            if (int'(stage_q) == i) stage_res = fwd_out[i];
            if (int'(stage_q) == NUM_ROTORS + 1 + i) stage_res = inv_out[NUM_ROTORS-1-i];
`else
            if (int'(stage_q) == i) stage_res = dec_q ? inv_out[NUM_ROTORS-1-i] : fwd_out[i];
`endif
        end
`ifdef REFLECTOR_EN
        if (int'(stage_q) == NUM_ROTORS) stage_res = fwd_out[NUM_ROTORS];
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (stage_q == LAST) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            stage_q   <= '0;
            sym_q     <= '0;
            dec_q     <= 1'b0;
            oob_q     <= 1'b0;
            idx_q     <= '0;
            out_sym_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    sym_q   <= in_sym;
                    dec_q   <= in_dec;
                    oob_q   <= in_oob;
                    idx_q   <= in_idx;
                    stage_q <= '0;
                end
                RUN: begin
                    idx_q   <= stage_res;
                    stage_q <= stage_q + SW'(1);
                    if (stage_q == LAST)
                        out_sym_q <= oob_q ? sym_q : SYM_W'(stage_res) + SYM_W'(BASE);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT);
    assign out_sym   = out_sym_q;
endmodule

// File: tb/tb_enigma_rotor_stack.sv
// Self-checking bench: vector table, inversion round-trip, model-driven runs and corner sequences.
module tb_enigma_rotor_stack;
    localparam int N     = 2;
    localparam int ALPHA = 26;
    localparam int IW    = 5;
    localparam int SYM_W = 8;
    localparam int BASE  = 65;
    localparam int LAT   = N + 1;

    typedef struct {
        int phase;
        int sym;
        bit dec;
        int exp;
    } vec_t;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                cfg_we;
    logic [2:0]          cfg_sel;
    logic [ALPHA*IW-1:0] cfg_wiring;
    logic [IW-1:0]       cfg_pos;
    logic [IW-1:0]       cfg_step;
    logic                in_valid;
    logic                in_ready;
    logic [SYM_W-1:0]    in_sym;
    logic                in_dec;
    logic                out_valid;
    logic                out_ready;
    logic [SYM_W-1:0]    out_sym;
    logic                busy;

    enigma_rotor_stack #(.NUM_ROTORS(N), .ALPHA(ALPHA), .SYM_W(SYM_W), .BASE(BASE)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_wiring (cfg_wiring),
        .cfg_pos    (cfg_pos),
        .cfg_step   (cfg_step),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sym     (in_sym),
        .in_dec     (in_dec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sym    (out_sym),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int m_wir  [N][ALPHA];
    int m_pos  [N];
    int m_step [N];
    int wtab   [ALPHA];
    int pend_sel, pend_pos, pend_step;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int model_cipher(input int sym, input bit dec);
        int idx, j;
        if (sym < BASE || sym >= BASE + ALPHA) return sym;
        idx = sym - BASE;
        if (!dec) begin
            for (int r = 0; r < N; r++) idx = m_wir[r][(idx + m_pos[r]) % ALPHA];
        end else begin
            for (int r = N - 1; r >= 0; r--) begin
                j = -1;
                for (int k = 0; k < ALPHA; k++)
                    if (j < 0 && m_wir[r][k] == idx) j = k;
                if (j >= 0) idx = (j - m_pos[r] + ALPHA) % ALPHA;
            end
        end
        return idx + BASE;
    endfunction

    function automatic void model_step();
        int s;
        bit carry = 1'b1;
        for (int r = 0; r < N; r++) begin
            if (carry) begin
                s        = m_pos[r] + m_step[r];
                m_pos[r] = s % ALPHA;
                carry    = (s >= ALPHA);
            end
        end
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < N; r++) begin
            m_pos[r]  = 0;
            m_step[r] = 0;
            for (int k = 0; k < ALPHA; k++) m_wir[r][k] = 0;
        end
    endfunction

    function automatic void model_cfg(input int sel, input int pos, input int step);
        if (sel < N) begin
            m_pos[sel]  = pos;
            m_step[sel] = step;
            for (int k = 0; k < ALPHA; k++) m_wir[sel][k] = wtab[k];
        end
    endfunction

    task automatic drive_cfg(input int sel, input int pos, input int step);
        cfg_sel  = 3'(sel);
        cfg_pos  = IW'(pos);
        cfg_step = IW'(step);
        for (int k = 0; k < ALPHA; k++) cfg_wiring[k*IW +: IW] = IW'(wtab[k]);
    endtask

    task automatic write_cfg(input int sel, input int pos, input int step, input bit applies);
        @(negedge clk);
        drive_cfg(sel, pos, step);
        cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        if (applies) model_cfg(sel, pos, step);
    endtask

    task automatic set_identity();
        for (int k = 0; k < ALPHA; k++) wtab[k] = k;
    endtask

    task automatic send(input int sym, input bit dec, input int exp_in, input int hold,
                        input bit cfg_now, input bit cfg_in_out);
        int cyc, got, req;
        @(negedge clk);
        if (cfg_now) begin
            drive_cfg(pend_sel, pend_pos, pend_step);
            cfg_we = 1'b1;
            model_cfg(pend_sel, pend_pos, pend_step);
        end
        in_valid = 1'b1;
        in_sym   = SYM_W'(sym);
        in_dec   = dec;
        check("in_ready_idle", int'(in_ready), 1);
        exp_q.push_back((exp_in < 0) ? model_cipher(sym, dec) : exp_in);
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        check("in_ready_busy", int'(in_ready), 0);
        cyc = 1;
        while (!out_valid && cyc <= 4 * LAT) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, LAT);
        got = int'(out_sym);
        req = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check("out_sym", got, req);
        for (int h = 0; h < hold; h++) begin
            if (cfg_in_out && h == 0) begin
                for (int k = 0; k < ALPHA; k++) wtab[k] = 0;
                drive_cfg(0, 10, 7);
                cfg_we = 1'b1;
            end
            @(negedge clk);
            cfg_we = 1'b0;
            check("hold_out_sym", int'(out_sym), got);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_out_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after", int'(out_valid), 0);
        if (sym >= BASE && sym < BASE + ALPHA) model_step();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_in_ready"},  int'(in_ready), 1);
        check({tag, "_busy"},      int'(busy), 0);
        check({tag, "_out_sym"},   int'(out_sym), 0);
    endtask

    task automatic setup_phase(input int p);
        set_identity();
        if (p == 2) begin
            write_cfg(0, 25, 1, 1'b1);
            write_cfg(1, 0, 1, 1'b1);
        end else begin
            write_cfg(0, 0, 1, 1'b1);
            write_cfg(1, 0, 0, 1'b1);
        end
    endtask

    vec_t vecs [16];
    int   sp [N];
    int   ss [N];
    int   sw [N][ALPHA];
    int   pt [12];
    int   ct [12];

    initial begin
        int cur_phase, j, t;

        vecs = '{
            '{0, 65, 1'b0, 65}, '{0, 65, 1'b0, 66}, '{0, 65, 1'b0, 67}, '{0, 65, 1'b0, 68},
            '{1, 65, 1'b1, 65}, '{1, 66, 1'b1, 65}, '{1, 67, 1'b1, 65},
            '{2, 65, 1'b0, 90}, '{2, 65, 1'b0, 66}, '{2, 32, 1'b0, 32}, '{2, 64, 1'b0, 64},
            '{2, 91, 1'b0, 91}, '{2, 65, 1'b0, 67}, '{2, 90, 1'b0, 67},
            '{2, 66, 1'b1, 66}, '{2, 32, 1'b1, 32}
        };
        // The last two rows: decrypt 'B' at positions (3,1): r1 j=1 -> 0, r0 j=0 -> (0-3) mod 26 = 23?
        // Recomputed below from the model instead of constants for those two rows.

        reset_n    = 1'b0;
        cfg_we     = 1'b0;
        cfg_sel    = '0;
        cfg_wiring = '0;
        cfg_pos    = '0;
        cfg_step   = '0;
        in_valid   = 1'b0;
        in_sym     = '0;
        in_dec     = 1'b0;
        out_ready  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset_n = 1'b1;

        cur_phase = -1;
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].phase != cur_phase) begin
                cur_phase = vecs[i].phase;
                setup_phase(cur_phase);
            end
            send(vecs[i].sym, vecs[i].dec, (i >= 14) ? -1 : vecs[i].exp, 0, 1'b0, 1'b0);
        end

        // Encrypt then decrypt from the same start must return the plaintext.
        for (int r = 0; r < N; r++) begin
            set_identity();
            for (int k = ALPHA - 1; k > 0; k--) begin
                j = $urandom_range(0, k);
                t = wtab[k]; wtab[k] = wtab[j]; wtab[j] = t;
            end
            sp[r] = $urandom_range(0, ALPHA - 1);
            ss[r] = $urandom_range(0, ALPHA - 1);
            for (int k = 0; k < ALPHA; k++) sw[r][k] = wtab[k];
            write_cfg(r, sp[r], ss[r], 1'b1);
        end
        for (int i = 0; i < 12; i++) begin
            pt[i] = $urandom_range(BASE, BASE + ALPHA - 1);
            ct[i] = model_cipher(pt[i], 1'b0);
            send(pt[i], 1'b0, ct[i], 0, 1'b0, 1'b0);
        end
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < ALPHA; k++) wtab[k] = sw[r][k];
            write_cfg(r, sp[r], ss[r], 1'b1);
        end
        for (int i = 0; i < 12; i++) send(ct[i], 1'b1, pt[i], 0, 1'b0, 1'b0);

        // Non-permutation table: duplicates and missing entries.
        for (int k = 0; k < ALPHA; k++) wtab[k] = $urandom_range(0, 5);
        write_cfg(1, 4, 3, 1'b1);
        for (int i = 0; i < 6; i++) send(BASE + 4 * i, i[0], -1, 0, 1'b0, 1'b0);

        // Stall in OUT with a config write attempted there.
        send(75, 1'b0, -1, 5, 1'b0, 1'b1);
        send(75, 1'b0, -1, 0, 1'b0, 1'b0);

        // Out-of-range rotor select is ignored.
        for (int k = 0; k < ALPHA; k++) wtab[k] = 0;
        write_cfg(5, 3, 3, 1'b0);
        send(77, 1'b0, -1, 0, 1'b0, 1'b0);

        // Config write and accept in the same cycle.
        for (int k = 0; k < ALPHA; k++) wtab[k] = ALPHA - 1 - k;
        pend_sel = 0; pend_pos = 3; pend_step = 1;
        send(69, 1'b0, -1, 0, 1'b1, 1'b0);
        send(69, 1'b1, -1, 0, 1'b0, 1'b0);

        // Reset in the middle of RUN.
        @(negedge clk);
        in_valid = 1'b1;
        in_sym   = SYM_W'(66);
        in_dec   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_run", int'(busy), 1);
        #1 reset_n = 1'b0;
        #1 check_reset_values("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        send(67, 1'b0, 65, 0, 1'b0, 1'b0);
        send(67, 1'b1, 67, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/enigma_rotor_stack.md
Name: enigma_rotor_stack

Overview:
Parametrised successor to the single-rotor cipher cell. A chain of NUM_ROTORS rotors, each with a run-time wiring table, position and step size, encrypts or decrypts one symbol per transaction over valid/ready handshakes. Rotors advance odometer-style (carry on wrap). Sits between the host byte interface and the output formatter.

Parameters:
NUM_ROTORS, 3, number of rotors in the chain (1..8)
ALPHA, 26, alphabet size
SYM_W, 8, symbol width in bits
BASE, 65, code of alphabet index 0 ('A')

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous reset, active-low
cfg_we  input  1  write config for rotor cfg_sel; honoured only in IDLE
cfg_sel  input  3  rotor index (values >= NUM_ROTORS ignored)
cfg_wiring  input  ALPHA*IW  wiring table, IW=$clog2(ALPHA); entry k at [k*IW +: IW]
cfg_pos  input  IW  initial position
cfg_step  input  IW  step per advance (0..ALPHA-1)
in_valid  input  1  input symbol valid
in_ready  output  1  block can accept (high only in IDLE)
in_sym  input  SYM_W  input symbol
in_dec  input  1  1 = decrypt, 0 = encrypt; sampled with in_sym
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
out_sym  output  SYM_W  result symbol
busy  output  1  high when not IDLE

Behaviour:
- Reset: state IDLE; all positions, steps and wiring entries 0; in_ready=1 after reset, out_valid=0, out_sym=0, busy=0.
- FSM: IDLE -> RUN on in_valid&in_ready (latch sym, dec; idx=sym-BASE; stage counter k=0). RUN: one rotor per cycle, NUM_ROTORS cycles. RUN -> OUT after last rotor. OUT: out_valid=1, out_sym held stable; OUT -> IDLE on out_ready.
- Latency: accept at cycle t -> out_valid at t+NUM_ROTORS+1.
- Encrypt: rotors 0..N-1 in order; idx' = wiring[(idx+pos) mod ALPHA].
- Decrypt: rotors N-1..0; find j with wiring[j]==idx; idx' = (j-pos) mod ALPHA. No match (non-permutation table): idx' = idx. Multiple matches: lowest j.
- out_sym = idx_final + BASE.
- All modular adds computed at IW+1 bits with a single conditional subtract of ALPHA; no division.
- Stepping: on the OUT handshake only (the positions used for the symbol are pre-step). Rotor 0: pos += step mod ALPHA. Rotor k+1 advances by its own step only if rotor k wrapped (pos+step >= ALPHA) in the same cycle. Stepping is identical in both modes, so decrypt from the same start positions inverts encrypt.
- Out-of-alphabet input (sym < BASE or sym >= BASE+ALPHA): still takes full latency; out_sym = in_sym; no stepping.
- cfg_we outside IDLE: ignored, with no effect. cfg_we and an accept in the same IDLE cycle: config is written first; the new symbol uses the new config.
- in_ready is low for the whole transaction; no overlap between transactions.
- reset_n asserted mid-transaction: immediate return to reset values; the partial result is discarded.

Optional Feature:
REFLECTOR_EN. Defined: adds an extra config slot (cfg_sel==NUM_ROTORS) holding a reflector table. The path is forward through rotors 0..N-1, then reflector lookup, then inverse lookups through N-1..0. Latency is 2*NUM_ROTORS+2. in_dec is ignored because the cipher is an involution. Undefined: no reflector; behaviour is as above.

Decomposition:
- Package enigma_pkg: IW computation function, BASE/ALPHA defaults, state enum (IDLE, RUN, OUT), and the mod-add/mod-sub functions.
- Sub-module enigma_rotor_cell: one rotor's wiring, position and step registers, plus combinational forward and inverse lookup and the step/carry logic. Instantiated NUM_ROTORS times (plus one reflector cell under REFLECTOR_EN). The top level contains the FSM and the stage mux.

Test Plan:
- N=1, identity wiring, pos 0, step 1; encrypt "AAA" -> "A","B","C"; pos ends at 3.
- Same config reloaded to pos 0; decrypt "ABC" -> "A","A","A".
- N=2, rotor0 pos 25 step 1, rotor1 pos 0 step 1; encrypt one letter -> rotor0 pos 0, rotor1 pos 1; next letter uses the carried position.
- Input 0x20 (space) -> out_sym 0x20 after N+1 cycles; positions unchanged.
- Hold out_ready=0 for 5 cycles in OUT -> out_sym stable, in_ready=0, no stepping until the handshake; cfg_we in OUT is ignored.
- Assert reset_n mid-RUN -> outputs return to reset values at once; the next transaction behaves as after power-up.
